// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   Issue/retire controller for a fixed-latency, non-stallable multiplier
//   shared by two requesters. Each accepted request is followed through a
//   LAT-deep tracking pipe that runs alongside the datapath. When a result
//   leaves the datapath its {src, tag} is written to a small tag FIFO that
//   mirrors the result buffer. Issue is credit-gated so that every result
//   in flight is guaranteed a free buffer slot. Responses pop in issue order.
//
// Parameters
//   LAT    datapath latency in cycles (1..8)
//   DEPTH  result-buffer entries, power of two (2..16)
//   TAG_W  requester tag width
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req0_valid/req0_tag       requester 0 operand pair present, its tag
//   req1_valid/req1_tag       requester 1 operand pair present, its tag
//   req0_ready/req1_ready     accept strobes (combinational)
//   iss_valid, iss_sel        launch strobe and operand mux select
//   buf_wr_en, buf_wr_ptr     result-buffer write strobe and address
//   buf_rd_ptr                result-buffer read address
//   rsp_valid/rsp_src/rsp_tag head-of-buffer response
//   rsp_ready                 consumer pops the head response
//   busy                      anything in flight or buffered

module mul_issue_ctrl #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [TAG_W-1:0]         req0_tag,
    input  logic                     req1_valid,
    input  logic [TAG_W-1:0]         req1_tag,
    output logic                     req0_ready,
    output logic                     req1_ready,
    output logic                     iss_valid,
    output logic                     iss_sel,
    output logic                     buf_wr_en,
    output logic [$clog2(DEPTH)-1:0] buf_wr_ptr,
    output logic [$clog2(DEPTH)-1:0] buf_rd_ptr,
    output logic                     rsp_valid,
    output logic                     rsp_src,
    output logic [TAG_W-1:0]         rsp_tag,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    // tracking pipe, stage LAT-1 is the one leaving the datapath
    logic [LAT-1:0]            r_trk_vld;
    logic [LAT-1:0]            r_trk_src;
    logic [LAT-1:0][TAG_W-1:0] r_trk_tag;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_inflight;
    logic             r_last;

    logic             r_fifo_src [DEPTH];
    logic [TAG_W-1:0] r_fifo_tag [DEPTH];

    logic             w_credit;
    logic             w_sel;
    logic             w_issue;
    logic             w_retire;
    logic             w_pop;
    logic [CNT_W:0]   w_used;

    // Credit uses registered counts only; a pop frees its slot for issue
    // one cycle later, which keeps ready independent of rsp_ready.
    assign w_used   = {1'b0, r_inflight} + {1'b0, r_occ};
    assign w_credit = !rst && (w_used < {1'b0, C_FULL});

    // r_last = 1 means requester 1 was granted last, so 0 wins a tie.
    assign w_sel    = req1_valid && (!req0_valid || !r_last);
    assign w_issue  = w_credit && (req0_valid || req1_valid);
    assign w_retire = r_trk_vld[LAT-1];
    assign w_pop    = rsp_valid && rsp_ready;

    assign req0_ready = w_credit && !w_sel;
    assign req1_ready = w_credit && w_sel;
    assign iss_valid  = w_issue;
    assign iss_sel    = w_sel;
    assign buf_wr_en  = w_retire;
    assign buf_wr_ptr = r_wr_ptr;
    assign buf_rd_ptr = r_rd_ptr;
    assign rsp_valid  = (r_occ != '0);
    assign rsp_src    = r_fifo_src[r_rd_ptr];
    assign rsp_tag    = r_fifo_tag[r_rd_ptr];
    assign busy       = (r_inflight != '0) || (r_occ != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trk_vld  <= '0;
            r_trk_src  <= '0;
            r_trk_tag  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_inflight <= '0;
            r_last     <= 1'b1;
        end else begin
            r_trk_vld[0] <= w_issue;
            r_trk_src[0] <= w_sel;
            r_trk_tag[0] <= w_sel ? req1_tag : req0_tag;
            for (int i = 1; i < LAT; i++) begin
                r_trk_vld[i] <= r_trk_vld[i-1];
                r_trk_src[i] <= r_trk_src[i-1];
                r_trk_tag[i] <= r_trk_tag[i-1];
            end

            if (w_retire) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            case ({w_issue, w_retire})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase

            case ({w_retire, w_pop})
                2'b10:   r_occ <= r_occ + CNT_W'(1);
                2'b01:   r_occ <= r_occ - CNT_W'(1);
                default: r_occ <= r_occ;
            endcase

            if (w_issue) r_last <= w_sel;
        end
    end

    // tag FIFO storage; contents are don't-care while the entry is empty
    always_ff @(posedge clk) begin
        if (w_retire) begin
            r_fifo_src[r_wr_ptr] <= r_trk_src[LAT-1];
            r_fifo_tag[r_wr_ptr] <= r_trk_tag[LAT-1];
        end
    end

`ifndef SYN
    always_ff @(posedge clk) begin
        if (!rst && w_retire) begin
            assert (r_occ != C_FULL)
                else $error("mul_issue_ctrl: result written into a full buffer");
        end
    end
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [3:0] req0_tag;
    logic       req1_valid;
    logic [3:0] req1_tag;
    logic       req0_ready;
    logic       req1_ready;
    logic       iss_valid;
    logic       iss_sel;
    logic       buf_wr_en;
    logic [1:0] buf_wr_ptr;
    logic [1:0] buf_rd_ptr;
    logic       rsp_valid;
    logic       rsp_src;
    logic [3:0] rsp_tag;
    logic       rsp_ready;
    logic       busy;

    int n_assert;
    int n_fail;
    int n_iss;
    int n_wr;
    int n_rsp;

    mul_issue_ctrl #(.LAT(3), .DEPTH(4), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_tag   (req1_tag),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .iss_valid  (iss_valid),
        .iss_sel    (iss_sel),
        .buf_wr_en  (buf_wr_en),
        .buf_wr_ptr (buf_wr_ptr),
        .buf_rd_ptr (buf_rd_ptr),
        .rsp_valid  (rsp_valid),
        .rsp_src    (rsp_src),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
            end
    endtask

    // leaves the bench at posedge+1 of cycle 0 with reset released
    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_tag = '0;
        req1_tag = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;

        // reset state, with requests pending
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_tag = 4'd1;
        req1_tag = 4'd2;
        rsp_ready = 1'b1;
        #2;
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_wr_en", buf_wr_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);

        // single op
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1;
        req0_tag = 4'd5;
        #1;
        chk("single_iss_valid", iss_valid, 1);
        chk("single_iss_sel", iss_sel, 0);
        chk("single_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("single_c1_wr_en", buf_wr_en, 0);
        chk("single_c1_busy", busy, 1);
        tick();
        #1;
        chk("single_c2_wr_en", buf_wr_en, 0);
        tick();
        #1;
        chk("single_c3_wr_en", buf_wr_en, 1);
        chk("single_c3_wr_ptr", buf_wr_ptr, 0);
        chk("single_c3_rsp_valid", rsp_valid, 0);
        tick();
        #1;
        chk("single_c4_rsp_valid", rsp_valid, 1);
        chk("single_c4_rsp_src", rsp_src, 0);
        chk("single_c4_rsp_tag", rsp_tag, 5);
        tick();
        #1;
        chk("single_c5_rsp_valid", rsp_valid, 0);
        chk("single_c5_busy", busy, 0);
        chk("single_c5_rd_ptr", buf_rd_ptr, 1);

        // fairness: both valid, grants alternate until credit runs out
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_tag = 4'd1;
        req1_tag = 4'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_iss_valid", iss_valid, 1);
            chk("rr_iss_sel", iss_sel, 32'(k % 2));
            tick();
        end
        #1;
        chk("rr_c4_credit_stall", iss_valid, 0);
        chk("rr_c4_rsp_src", rsp_src, 0);
        chk("rr_c4_rsp_tag", rsp_tag, 1);
        tick();
        #1;
        chk("rr_c5_iss_valid", iss_valid, 1);
        chk("rr_c5_iss_sel", iss_sel, 0);
        chk("rr_c5_rsp_src", rsp_src, 1);
        chk("rr_c5_rsp_tag", rsp_tag, 2);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // only requester 1 valid, then a tie goes back to requester 0
        do_reset();
        rsp_ready = 1'b1;
        req1_valid = 1'b1;
        req1_tag = 4'd7;
        #1;
        chk("solo1_iss_sel", iss_sel, 1);
        chk("solo1_req1_ready", req1_ready, 1);
        chk("solo1_req0_ready", req0_ready, 0);
        tick();
        req0_valid = 1'b1;
        #1;
        chk("solo1_tie_sel", iss_sel, 0);
        chk("solo1_tie_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // backpressure: four issues fill the buffer
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        n_iss = 0;
        for (int k = 0; k < 8; k++) begin
            req0_tag = 4'(k);
            #1;
            if (iss_valid) n_iss++;
            if (k >= 4) chk("bp_ready_low", req0_ready, 0);
            tick();
        end
        chk("bp_issue_count", n_iss, 4);
        // A: buffer full, pop one
        rsp_ready = 1'b1;
        #1;
        chk("bp_a_iss_valid", iss_valid, 0);
        chk("bp_a_rsp_tag", rsp_tag, 0);
        tick();
        // A+1: popped slot lets one issue through
        rsp_ready = 1'b0;
        req0_tag = 4'd4;
        #1;
        chk("bp_a1_resume", iss_valid, 1);
        tick();
        // A+2
        req0_tag = 4'd5;
        rsp_ready = 1'b1;
        #1;
        chk("bp_a2_iss_valid", iss_valid, 0);
        chk("bp_a2_rsp_tag", rsp_tag, 1);
        tick();
        // A+3
        rsp_ready = 1'b0;
        #1;
        chk("bp_a3_resume", iss_valid, 1);
        tick();
        // A+4: tag 4 retires, occupancy goes 2 -> 3
        req0_tag = 4'd6;
        #1;
        chk("bp_a4_iss_valid", iss_valid, 0);
        chk("bp_a4_wr_en", buf_wr_en, 1);
        tick();
        #1;
        chk("bp_a5_iss_valid", iss_valid, 0);
        tick();
        // A+6: retire and pop together at occupancy DEPTH-1
        rsp_ready = 1'b1;
        #1;
        chk("sim_wr_en", buf_wr_en, 1);
        chk("sim_wr_ptr", buf_wr_ptr, 1);
        chk("sim_rd_ptr", buf_rd_ptr, 2);
        chk("sim_rsp_tag", rsp_tag, 2);
        chk("sim_iss_valid", iss_valid, 0);
        tick();
        // A+7: occupancy stayed 3, nothing in flight -> one credit
        rsp_ready = 1'b0;
        #1;
        chk("sim_credit", iss_valid, 1);
        tick();
        #1;
        chk("sim_full", iss_valid, 0);
        chk("sim_rsp_tag_next", rsp_tag, 3);
        tick();
        req0_valid = 1'b0;

        // wrap: ten back-to-back ops through a four-entry buffer
        do_reset();
        rsp_ready = 1'b1;
        n_iss = 0;
        n_wr = 0;
        n_rsp = 0;
        for (int cyc = 0; cyc < 80 && n_rsp < 10; cyc++) begin
            req0_valid = (n_iss < 10);
            req0_tag = 4'(n_iss);
            #1;
            if (iss_valid) n_iss++;
            if (buf_wr_en) begin
                chk("wrap_wr_ptr", buf_wr_ptr, 32'(n_wr % 4));
                n_wr++;
            end
            if (rsp_valid) begin
                chk("wrap_rsp_tag", rsp_tag, 32'(n_rsp));
                chk("wrap_rd_ptr", buf_rd_ptr, 32'(n_rsp % 4));
                chk("wrap_rsp_src", rsp_src, 0);
                n_rsp++;
            end
            tick();
        end
        chk("wrap_rsp_count", n_rsp, 10);
        req0_valid = 1'b0;

        // reset with two results in flight and two buffered
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req0_tag = 4'(k + 8);
            tick();
        end
        #1;
        chk("mid_pre_busy", busy, 1);
        chk("mid_pre_rsp_valid", rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_wr_en", buf_wr_en, 0);
        chk("mid_rst_iss_valid", iss_valid, 0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("mid_post_wr_en", buf_wr_en, 0);
            chk("mid_post_busy", busy, 0);
            chk("mid_post_rsp_valid", rsp_valid, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter LAT, default 3: fixed latency of the non-stallable multiplier datapath in cycles, legal range 1..8.
REQ-002 Parameter DEPTH, default 4: number of result-buffer entries, power of two, legal range 2..16.
REQ-003 Parameter TAG_W, default 4: width of the requester tag.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports SHALL be as listed below.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req0_valid / req1_valid  in  1  requester 0/1 has an operand pair.
- req0_tag / req1_tag  in  TAG_W  requester tag.
- req0_ready / req1_ready  out  1  request accepted this cycle when ready and valid are both high.
- iss_valid  out  1  operands launched into the datapath this cycle.
- iss_sel  out  1  datapath operand mux select; 0 selects requester 0.
- buf_wr_en  out  1  result-buffer write strobe.
- buf_wr_ptr  out  $clog2(DEPTH)  result-buffer write address.
- buf_rd_ptr  out  $clog2(DEPTH)  result-buffer read address.
- rsp_valid  out  1  response available.
- rsp_src  out  1  originating requester.
- rsp_tag  out  TAG_W  originating tag.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high while any operation is in flight or buffered.

Function
REQ-006 Credit rule: at most one issue per cycle, and only when inflight + occupancy < DEPTH. inflight counts valid stages in the tracking pipe; occupancy counts buffered results.
REQ-007 Arbitration is round-robin.
- When both requests are valid, grant the requester not granted last; the last-grant flag updates only on an issue.
- When only one request is valid, grant it.
- When no credit is available, drive both readys low.
REQ-008 req*_ready is combinational from valids, credit and the last-grant flag; it SHALL NOT depend on rsp_ready.
REQ-009 On grant, in the same cycle: iss_valid=1, iss_sel=granted index, and {1, src, tag} enters stage 0 of a LAT-deep tracking shift register.
REQ-010 The tracking register shifts every cycle unconditionally.
- When stage LAT-1 is valid, assert buf_wr_en and write {src, tag} into the tag FIFO at buf_wr_ptr.
- buf_wr_ptr then increments modulo DEPTH.
- An issue in cycle N therefore produces buf_wr_en in cycle N+LAT.
REQ-011 rsp_valid = occupancy != 0. rsp_src/rsp_tag come from the tag FIFO at buf_rd_ptr.
- On rsp_valid && rsp_ready, buf_rd_ptr increments modulo DEPTH.
REQ-012 Simultaneous write and read in one cycle leaves occupancy unchanged.
- Counter updates SHALL be computed from all of issue, retire and pop in that cycle.
REQ-013 Wrap-around of both pointers is natural binary modulo DEPTH. Occupancy is tracked by a counter of width $clog2(DEPTH)+1.
REQ-014 Credit accounting guarantees a write never lands on a full buffer.
- A write to a full buffer is a design error.
- A simulation assertion SHALL fire on it (excluded under SYN).
REQ-015 Responses return in issue order; there is no reordering.
REQ-016 busy = (inflight != 0) || (occupancy != 0).

Reset
REQ-017 Reset clears all of the following: tracking register valids, both pointers, occupancy, inflight, last-grant (=1, so requester 0 wins first).
REQ-018 During reset: iss_valid=0, buf_wr_en=0, rsp_valid=0, req*_ready=0, busy=0.
REQ-019 Reset asserted mid-operation discards all in-flight and buffered results, with no buf_wr_en after reset.
REQ-020 The first issue may occur in the first cycle after reset deasserts.

Verification
REQ-021 Single op: LAT=3, req0_valid with tag=5 at cycle 0, rsp_ready=1 -> iss_valid and iss_sel=0 at cycle 0; buf_wr_en at cycle 3 with wr_ptr=0; rsp_valid with src=0, tag=5 at cycle 4.
REQ-022 Fairness: both requesters valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1 every cycle.
REQ-023 Backpressure: DEPTH=4, rsp_ready=0, req0 valid continuously -> exactly 4 issues, then req0_ready=0. Raising rsp_ready resumes one issue per pop.
REQ-024 Wrap: 10 back-to-back ops with DEPTH=4 -> wr_ptr and rd_ptr each cycle 0..3; tags return in order.
REQ-025 Simultaneous events: a pop in the same cycle as a retire with occupancy=DEPTH-1 -> occupancy stays DEPTH-1 and the credit check holds.
REQ-026 Reset with 2 in flight and 2 buffered -> next cycle busy=0, rsp_valid=0, and no later buf_wr_en.
